// File: rtl/axil_arb_2to1.sv
`default_nettype none
// ============================================================================
// axil_arb_2to1 : round-robin 2:1 AXI4-Lite arbiter, one transaction in flight,
//                 reads and writes serialized. Watchdog: AXIL_ARB_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
module axil_arb_2to1 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [2:0]              s0_awprot,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  output logic [1:0]              s0_bresp,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [2:0]              s0_arprot,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [2:0]              s1_awprot,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  output logic [1:0]              s1_bresp,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [2:0]              s1_arprot,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  output logic                    timeout_flag
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_wr_addr = 3'd1;
  localparam logic [2:0] c_st_wr_resp = 3'd2;
  localparam logic [2:0] c_st_rd_addr = 3'd3;
  localparam logic [2:0] c_st_rd_data = 3'd4;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_q, rr_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       to_hit, absorb;

  logic                    sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [ADDR_WIDTH-1:0]   sel_awaddr, sel_araddr;
  logic [2:0]              sel_awprot, sel_arprot;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_wstrb;

  logic                  up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
  logic [1:0]            up_bresp, up_rresp;
  logic [DATA_WIDTH-1:0] up_rdata;

  logic req_wr0, req_wr1, req0, req1, pick, pick_wr;
  logic aw_now, w_now;

  assign sel_awvalid = grant_q ? s1_awvalid : s0_awvalid;
  assign sel_awaddr  = grant_q ? s1_awaddr  : s0_awaddr;
  assign sel_awprot  = grant_q ? s1_awprot  : s0_awprot;
  assign sel_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
  assign sel_wdata   = grant_q ? s1_wdata   : s0_wdata;
  assign sel_wstrb   = grant_q ? s1_wstrb   : s0_wstrb;
  assign sel_bready  = grant_q ? s1_bready  : s0_bready;
  assign sel_arvalid = grant_q ? s1_arvalid : s0_arvalid;
  assign sel_araddr  = grant_q ? s1_araddr  : s0_araddr;
  assign sel_arprot  = grant_q ? s1_arprot  : s0_arprot;
  assign sel_rready  = grant_q ? s1_rready  : s0_rready;

  assign req_wr0 = s0_awvalid & s0_wvalid;
  assign req_wr1 = s1_awvalid & s1_wvalid;
  assign req0    = req_wr0 | s0_arvalid;
  assign req1    = req_wr1 | s1_arvalid;
  // rr_q names the preferred master; it loses only when it has nothing to ask
  assign pick    = rr_q ? (req1 | ~req0) : (~req0 & req1);
  assign pick_wr = pick ? req_wr1 : req_wr0;
  assign aw_now  = aw_done_q | (m_awvalid & m_awready);
  assign w_now   = w_done_q | (m_wvalid & m_wready);

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_flag_q, timeout_flag_d;
  logic             absorb_q;
  logic             in_resp;

  assign in_resp = (state_q == c_st_wr_resp) || (state_q == c_st_rd_data);
  assign to_hit  = in_resp && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (in_resp) cnt_d = to_hit ? cnt_q : cnt_q + 1'b1;
    timeout_flag_d = timeout_flag_q | to_hit;
  end

  // absorb_q keeps the stray-response drain off while reset is asserted
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q          <= '0;
      timeout_flag_q <= 1'b0;
      absorb_q       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      timeout_flag_q <= timeout_flag_d;
      absorb_q       <= 1'b1;
    end
  end

  assign absorb       = absorb_q;
  assign timeout_flag = timeout_flag_q;
`else
  assign to_hit       = 1'b0;
  assign absorb       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= c_st_idle;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      c_st_idle: begin
        if (req0 | req1) begin
          grant_d   = pick;
          rr_d      = ~pick;
          state_d   = pick_wr ? c_st_wr_addr : c_st_rd_addr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      c_st_wr_addr: begin
        if (aw_now && w_now) begin
          state_d   = c_st_wr_resp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      c_st_wr_resp: if (up_bvalid & sel_bready) state_d = c_st_idle;
      c_st_rd_addr: if (m_arvalid & m_arready) state_d = c_st_rd_data;
      c_st_rd_data: if (up_rvalid & sel_rready) state_d = c_st_idle;
      default:      state_d = c_st_idle;
    endcase
  end

  always_comb begin
    m_awvalid  = 1'b0;
    m_awaddr   = '0;
    m_awprot   = '0;
    m_wvalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = absorb;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_arprot   = '0;
    m_rready   = absorb;
    up_awready = 1'b0;
    up_wready  = 1'b0;
    up_bvalid  = 1'b0;
    up_bresp   = 2'b00;
    up_arready = 1'b0;
    up_rvalid  = 1'b0;
    up_rdata   = '0;
    up_rresp   = 2'b00;
    case (state_q)
      c_st_wr_addr: begin
        m_awvalid  = sel_awvalid & ~aw_done_q;
        m_awaddr   = sel_awaddr;
        m_awprot   = sel_awprot;
        m_wvalid   = sel_wvalid & ~w_done_q;
        m_wdata    = sel_wdata;
        m_wstrb    = sel_wstrb;
        up_awready = m_awready & ~aw_done_q;
        up_wready  = m_wready & ~w_done_q;
      end
      c_st_wr_resp: begin
        m_rready  = 1'b0;
        m_bready  = to_hit | sel_bready;
        up_bvalid = to_hit | m_bvalid;
        up_bresp  = to_hit ? 2'b10 : m_bresp;
      end
      c_st_rd_addr: begin
        m_arvalid  = sel_arvalid;
        m_araddr   = sel_araddr;
        m_arprot   = sel_arprot;
        up_arready = m_arready;
      end
      c_st_rd_data: begin
        m_bready  = 1'b0;
        m_rready  = to_hit | sel_rready;
        up_rvalid = to_hit | m_rvalid;
        up_rdata  = to_hit ? '0 : m_rdata;
        up_rresp  = to_hit ? 2'b10 : m_rresp;
      end
      default: ;
    endcase
  end

  assign s0_awready = up_awready & ~grant_q;
  assign s1_awready = up_awready & grant_q;
  assign s0_wready  = up_wready & ~grant_q;
  assign s1_wready  = up_wready & grant_q;
  assign s0_bvalid  = up_bvalid & ~grant_q;
  assign s1_bvalid  = up_bvalid & grant_q;
  assign s0_bresp   = grant_q ? 2'b00 : up_bresp;
  assign s1_bresp   = grant_q ? up_bresp : 2'b00;
  assign s0_arready = up_arready & ~grant_q;
  assign s1_arready = up_arready & grant_q;
  assign s0_rvalid  = up_rvalid & ~grant_q;
  assign s1_rvalid  = up_rvalid & grant_q;
  assign s0_rdata   = grant_q ? '0 : up_rdata;
  assign s1_rdata   = grant_q ? up_rdata : '0;
  assign s0_rresp   = grant_q ? 2'b00 : up_rresp;
  assign s1_rresp   = grant_q ? up_rresp : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_axil_arb_2to1.sv
`default_nettype none
// ============================================================================
// tb_axil_arb_2to1 : directed bench with a small memory slave behind the arbiter.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axil_arb_2to1;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic [1:0]  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr [2];
  logic [31:0] s_wdata  [2];
  logic [31:0] s_araddr [2];
  logic [2:0]  s_awprot [2];
  logic [2:0]  s_arprot [2];
  logic [3:0]  s_wstrb  [2];
  wire  [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  wire  [1:0]  s_bresp  [2];
  wire  [1:0]  s_rresp  [2];
  wire  [31:0] s_rdata  [2];

  wire         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  wire  [31:0] m_awaddr, m_wdata, m_araddr;
  wire  [2:0]  m_awprot, m_arprot;
  wire  [3:0]  m_wstrb;
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  wire         timeout_flag;

  axil_arb_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]), .s0_bresp(s_bresp[0]),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]), .s0_arprot(s_arprot[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]), .s1_bresp(s_bresp[1]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]), .s1_arprot(s_arprot[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .timeout_flag(timeout_flag)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // memory slave: decides readies at negedge, acts on handshakes one cycle later
  logic [31:0] mem [16];
  int   aw_delay = 0, w_delay = 0;
  bit   b_never = 0, inject_b = 0;
  int   aw_cnt, w_cnt;
  bit   have_aw, have_w, p_aw, p_w, p_b, p_ar, p_r;
  logic [31:0] sl_awaddr, sl_wdata, sl_araddr;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    {aw_cnt, w_cnt} = '0;
    {have_aw, have_w, p_aw, p_w, p_b, p_ar, p_r} = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        {have_aw, have_w, p_aw, p_w, p_b, p_ar, p_r} = '0;
        aw_cnt = 0; w_cnt = 0;
      end else begin
        if (p_aw) begin have_aw = 1; aw_cnt = 0; end
        if (p_w)  begin have_w = 1;  w_cnt = 0;  end
        if (p_b)  m_bvalid = 0;
        if (p_r)  m_rvalid = 0;
        if (p_ar) begin m_rvalid = 1; m_rdata = mem[sl_araddr[5:2]]; m_rresp = 2'b00; end
        if (have_aw && have_w) begin
          mem[sl_awaddr[5:2]] = sl_wdata;
          have_aw = 0; have_w = 0;
          if (!b_never) begin m_bvalid = 1; m_bresp = 2'b00; end
        end
        if (inject_b) begin m_bvalid = 1; m_bresp = 2'b00; inject_b = 0; end
        m_awready = m_awvalid && !have_aw && (aw_cnt >= aw_delay);
        if (m_awvalid && !m_awready) aw_cnt++;
        m_wready = m_wvalid && !have_w && (w_cnt >= w_delay);
        if (m_wvalid && !m_wready) w_cnt++;
        m_arready = m_arvalid && !m_rvalid;
        p_aw = m_awvalid & m_awready; if (p_aw) sl_awaddr = m_awaddr;
        p_w  = m_wvalid & m_wready;   if (p_w)  sl_wdata  = m_wdata;
        p_ar = m_arvalid & m_arready; if (p_ar) sl_araddr = m_araddr;
        p_b  = m_bvalid & m_bready;
        p_r  = m_rvalid & m_rready;
      end
    end
  end

  // observer: grant order, IDLE gaps, stray activity
  logic [31:0] ord [$];
  int   gaps [$];
  int   last_resp_cyc = -1;
  bit   act, prev_act = 0, s1_noise = 0;
  int   wstall = 0, bup_cnt = 0;
  logic [31:0] last_wdata = '0;

  always @(negedge ACLK) begin
    #2;
    act = m_awvalid | m_wvalid | m_arvalid;
    if (ARESETN) begin
      if (m_awvalid & m_awready) ord.push_back(m_awaddr);
      if (m_arvalid & m_arready) ord.push_back(m_araddr | 32'h8000_0000);
      if (m_wvalid & m_wready)   last_wdata = m_wdata;
      if (act && !prev_act && last_resp_cyc >= 0) gaps.push_back(cyc - last_resp_cyc);
      if ((m_bvalid & m_bready) | (m_rvalid & m_rready)) last_resp_cyc = cyc;
      if (s_awready[1] | s_wready[1] | s_bvalid[1] | s_arready[1] | s_rvalid[1]) s1_noise = 1;
      if (m_wvalid && !s_wready[0]) wstall++;
      if (s_bvalid != 2'b00) bup_cnt++;
    end
    prev_act = act;
  end

  // master tasks start and end at posedge+1
  task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d, input bit wait_b,
                        output logic [1:0] resp, output int blat);
    bit awd = 0, wd = 0;
    int n = 0;
    s_awvalid[m] = 1; s_awaddr[m] = a; s_wvalid[m] = 1; s_wdata[m] = d; s_wstrb[m] = 4'hF;
    while (!(awd && wd) && n < 200) begin
      @(negedge ACLK); #2;
      if (s_awvalid[m] && s_awready[m]) awd = 1;
      if (s_wvalid[m] && s_wready[m]) wd = 1;
      @(posedge ACLK); #1;
      if (awd) s_awvalid[m] = 0;
      if (wd)  s_wvalid[m] = 0;
      n++;
    end
    chk("wr_addr_done", {awd, wd}, 2'b11);
    s_awvalid[m] = 0; s_wvalid[m] = 0;
    resp = 2'b11; blat = 0;
    if (wait_b) begin
      n = 0;
      do begin @(negedge ACLK); #2; n++; end while (!s_bvalid[m] && n < 200);
      chk("wr_resp_seen", s_bvalid[m], 1);
      resp = s_bresp[m]; blat = n;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic mread(input int m, input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done = 0;
    int n = 0;
    s_arvalid[m] = 1; s_araddr[m] = a;
    while (!done && n < 200) begin
      @(negedge ACLK); #2;
      if (s_arready[m]) done = 1;
      @(posedge ACLK); #1;
      if (done) s_arvalid[m] = 0;
      n++;
    end
    chk("rd_addr_done", done, 1);
    s_arvalid[m] = 0;
    n = 0;
    do begin @(negedge ACLK); #2; n++; end while (!s_rvalid[m] && n < 200);
    chk("rd_data_seen", s_rvalid[m], 1);
    d = s_rdata[m]; resp = s_rresp[m];
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARESETN = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
  endtask

  logic [1:0]  r0, r1;
  logic [31:0] d0, d1;
  int          l0, l1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    s_bready = 2'b11; s_rready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = 32'hDEAD_BEE0; s_wdata[i] = 32'hCAFE_F00D; s_araddr[i] = 32'h1234_5678;
      s_awprot[i] = 3'b000; s_arprot[i] = 3'b000; s_wstrb[i] = 4'hF;
    end
    ARESETN = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_handshakes", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("rst_data", {m_awaddr, m_araddr}, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    ARESETN = 1;
    @(posedge ACLK); #1;

    // single master write then read-back
    ord.delete(); s1_noise = 0;
    mwrite(0, 32'h0, 32'h1, 1, r0, l0);
    chk("t1_bresp", r0, 2'b00);
    chk("t1_m_awaddr", ord.size() > 0 ? ord[0] : 32'hFFFF_FFFF, 32'h0);
    chk("t1_m_wdata", last_wdata, 32'h1);
    mread(0, 32'h0, d0, r0);
    chk("t1_rdata", d0, 32'h1);
    chk("t1_rresp", r0, 2'b00);
    chk("t1_s1_quiet", s1_noise, 0);

    // s0 writes interleaved with s1 reads
    ord.delete();
    for (int i = 0; i < 4; i++) begin
      mwrite(0, 32'(4 * i), 32'(i + 1), 1, r0, l0);
      chk("t2_bresp", r0, 2'b00);
      mread(1, 32'(4 * i), d1, r1);
      chk("t2_rdata", d1, 64'(i + 1));
      chk("t2_rresp", r1, 2'b00);
    end
    chk("t2_order_len", ord.size(), 8);
    if (ord.size() == 8) chk("t2_last_read_after_write", ord[7], 32'h8000_000C);

    // simultaneous continuous writers alternate
    do_reset();
    ord.delete(); gaps.delete(); last_resp_cyc = -1;
    fork
      begin mwrite(0, 32'h10, 32'hA, 1, r0, l0); mwrite(0, 32'h14, 32'hB, 1, r0, l0); end
      begin mwrite(1, 32'h20, 32'hC, 1, r1, l1); mwrite(1, 32'h24, 32'hD, 1, r1, l1); end
    join
    chk("t3_order_len", ord.size(), 4);
    if (ord.size() == 4) begin
      chk("t3_grant0", ord[0], 32'h10);
      chk("t3_grant1", ord[1], 32'h20);
      chk("t3_grant2", ord[2], 32'h14);
      chk("t3_grant3", ord[3], 32'h24);
    end
    chk("t3_gap_count", gaps.size(), 3);
    foreach (gaps[i]) chk("t3_idle_gap", gaps[i], 2);

    // W accepted 3 cycles after AW; s1 read waits
    ord.delete(); wstall = 0; aw_delay = 0; w_delay = 3;
    fork
      mwrite(0, 32'h28, 32'h55, 1, r0, l0);
      mread(1, 32'h28, d1, r1);
    join
    w_delay = 0;
    chk("t4_wready_stall", wstall, 3);
    chk("t4_bresp", r0, 2'b00);
    chk("t4_order_len", ord.size(), 2);
    if (ord.size() == 2) chk("t4_read_after_write", ord[1], 32'h8000_0028);
    chk("t4_rdata", d1, 32'h55);

`ifdef AXIL_ARB_TIMEOUT_EN
    // hung slave: watchdog answers on the 16th response cycle
    b_never = 1;
    mwrite(0, 32'h34, 32'h6, 1, r0, l0);
    chk("to_bresp", r0, 2'b10);
    chk("to_latency", l0, 16);
    chk("to_flag", timeout_flag, 1);
    b_never = 0;
    l1 = bup_cnt;
    inject_b = 1;
    repeat (4) @(posedge ACLK);
    #1;
    chk("to_stray_b_blocked", bup_cnt - l1, 0);
    chk("to_idle_bready", m_bready, 1);
`endif

    // asynchronous reset in WR_RESP, then a normal s1 read
    b_never = 1;
    mwrite(0, 32'h30, 32'h7, 0, r0, l0);
    chk("t5_in_wr_resp", m_bready, 1);
    ARESETN = 0;
    #1;
    chk("t5_async_rst", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    b_never = 0;
    @(posedge ACLK); #1;
    mread(1, 32'h4, d1, r1);
    chk("t5_rdata", d1, 32'h2);
    chk("t5_rresp", r1, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
